hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 96 +++++++++
 tb/tb_hazard_scoreboard.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Per-register result-latency countdowns that stall dependent
//               ID-stage instructions until their sources are forwardable.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int RA_W    = 5,
  parameter int LAT_W   = 3,
  parameter int MAX_LAT = 7,
  parameter int SCNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_flush,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [LAT_W-1:0]  id_lat,
  output logic              stall,
  output logic              issue,
  output logic [RA_W:0]     pending_cnt,
  output logic [SCNT_W-1:0] stall_cycles
);

  localparam logic [LAT_W-1:0]  c_max_lat  = LAT_W'(MAX_LAT);
  localparam logic [SCNT_W-1:0] c_scnt_max = '1;

  logic [LAT_W-1:0]  w_cnt [NREG];
  logic [LAT_W-1:0]  w_lat;
  logic              w_rs_busy;
  logic              w_rt_busy;
  logic              w_load;
  logic [RA_W:0]     w_pend;
  logic [SCNT_W-1:0] r_scnt;

  // Register 0 is hardwired: never tracked, always reads as ready.
  assign w_cnt[0] = '0;

  assign w_rs_busy = id_use_rs && (w_cnt[id_rs] != '0);
  assign w_rt_busy = id_use_rt && (w_cnt[id_rt] != '0);
  assign stall     = id_valid && !id_flush && (w_rs_busy || w_rt_busy);
  assign issue     = id_valid && !id_flush && !stall;

  assign w_lat  = (id_lat > c_max_lat) ? c_max_lat : id_lat;
  assign w_load = issue && id_wr && (id_rd != '0);

  generate
    for (genvar r = 1; r < NREG; r++) begin : g_cnt
      logic [LAT_W-1:0] r_cnt;
      logic [LAT_W-1:0] w_dec;

      assign w_dec = (r_cnt != '0) ? (r_cnt - LAT_W'(1)) : '0;

      // A WAW reload keeps the longer of the new latency and the remaining wait.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (w_load && (id_rd == RA_W'(r))) begin
          r_cnt <= (w_lat > w_dec) ? w_lat : w_dec;
        end else begin
          r_cnt <= w_dec;
        end
      end

      assign w_cnt[r] = r_cnt;
    end
  endgenerate

  always_comb begin
    w_pend = '0;
    for (int i = 1; i < NREG; i++) begin
      w_pend = w_pend + (RA_W+1)'(w_cnt[i] != '0);
    end
  end

  assign pending_cnt = w_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scnt <= '0;
    end else if (stall && (r_scnt != c_scnt_max)) begin
      r_scnt <= r_scnt + SCNT_W'(1);
    end
  end

  assign stall_cycles = r_scnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench; instance a uses defaults,
//               instance b uses MAX_LAT=3 and SCNT_W=4 on the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_flush, id_use_rs, id_use_rt, id_wr;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [2:0] id_lat;

  logic        stall_a, issue_a, stall_b, issue_b;
  logic [5:0]  pending_a, pending_b;
  logic [15:0] scnt_a;
  logic [3:0]  scnt_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr(id_wr), .id_rd(id_rd), .id_lat(id_lat),
    .stall(stall_a), .issue(issue_a), .pending_cnt(pending_a), .stall_cycles(scnt_a)
  );

  hazard_scoreboard #(.MAX_LAT(3), .SCNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr(id_wr), .id_rd(id_rd), .id_lat(id_lat),
    .stall(stall_b), .issue(issue_b), .pending_cnt(pending_b), .stall_cycles(scnt_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic fl,
                       input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic wr, input logic [4:0] rd, input logic [2:0] lat);
    id_valid  = v;   id_flush  = fl;
    id_rs     = rs;  id_use_rs = urs;
    id_rt     = rt;  id_use_rt = urt;
    id_wr     = wr;  id_rd     = rd;  id_lat = lat;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #10;
    check("rst_stall", stall_a, 0);
    check("rst_issue", issue_a, 0);
    check("rst_pending", pending_a, 0);
    check("rst_scnt", scnt_a, 0);
    tick();
    reset = 1'b0;

    // load r5 latency 1, dependent reader stalls one cycle
    drive(1, 0, 0, 0, 0, 0, 1, 5, 1);
    check("ld_issue", issue_a, 1);
    tick();
    drive(1, 0, 5, 1, 0, 0, 0, 0, 0);
    check("ld_stall", stall_a, 1);
    check("ld_issue_blk", issue_a, 0);
    check("ld_pending", pending_a, 1);
    tick();
    check("ld_stall_end", stall_a, 0);
    check("ld_issue_go", issue_a, 1);
    check("ld_scnt", scnt_a, 1);
    tick();

    // r7 latency 4 read through rt: four stall cycles
    drive(1, 0, 0, 0, 0, 0, 1, 7, 4);
    tick();
    drive(1, 0, 0, 0, 7, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      check("l4_stall", stall_a, 1);
      check("l4_pending", pending_a, 1);
      tick();
    end
    check("l4_stall_end", stall_a, 0);
    check("l4_issue", issue_a, 1);
    check("l4_pending0", pending_a, 0);
    check("l4_scnt", scnt_a, 5);
    tick();

    // WAW: r3 lat 5 then r3 lat 1 keeps the remaining 4
    drive(1, 0, 0, 0, 0, 0, 1, 3, 5);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 3, 1);
    check("waw_issue2", issue_a, 1);
    tick();
    drive(1, 0, 3, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      check("waw_stall", stall_a, 1);
      tick();
    end
    check("waw_stall_end", stall_a, 0);
    check("waw_scnt", scnt_a, 9);
    tick();

    // r0 is never tracked
    drive(1, 0, 0, 0, 0, 0, 1, 0, 7);
    tick();
    drive(1, 0, 0, 1, 0, 1, 0, 0, 0);
    check("r0_stall", stall_a, 0);
    check("r0_pending", pending_a, 0);
    tick();

    // flush suppresses stall/issue while the counter keeps running
    drive(1, 0, 0, 0, 0, 0, 1, 9, 2);
    tick();
    drive(1, 1, 9, 1, 0, 0, 0, 0, 0);
    check("fl_stall", stall_a, 0);
    check("fl_issue", issue_a, 0);
    tick();
    drive(1, 0, 9, 1, 0, 0, 0, 0, 0);
    check("fl_stall_after", stall_a, 1);
    tick();
    check("fl_issue_after", issue_a, 1);
    check("fl_scnt", scnt_a, 10);
    tick();

    // destination equal to source does not stall on itself
    drive(1, 0, 10, 1, 0, 0, 1, 10, 3);
    check("self_stall", stall_a, 0);
    check("self_issue", issue_a, 1);
    tick();
    idle();
    check("self_pending", pending_a, 1);
    repeat (3) tick();
    check("self_pending0", pending_a, 0);

    // instance b: latency 7 clamps to 3
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 1, 4, 7);
    check("clamp_issue", issue_b, 1);
    tick();
    drive(1, 0, 4, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check("clamp_stall", stall_b, 1);
      tick();
    end
    check("clamp_stall_end", stall_b, 0);
    check("clamp_scnt", scnt_b, 3);
    tick();

    // reset asserted mid-stall acts immediately
    drive(1, 0, 0, 0, 0, 0, 1, 4, 7);
    tick();
    drive(1, 0, 4, 1, 0, 0, 0, 0, 0);
    tick();
    check("mid_stall", stall_b, 1);
    check("mid_pending", pending_b, 1);
    reset = 1'b1;
    #1;
    check("ar_stall", stall_b, 0);
    check("ar_pending", pending_b, 0);
    check("ar_scnt", scnt_b, 0);
    idle();
    tick();
    reset = 1'b0;
    check("ar_pending_post", pending_b, 0);

    // self-reloading reader of r6 stalls 3 of every 4 cycles
    drive(1, 0, 6, 1, 0, 0, 1, 6, 3);
    repeat (12) tick();
    check("sat_mid", scnt_b, 9);
    repeat (8) tick();
    check("sat_15", scnt_b, 15);
    repeat (8) tick();
    check("sat_hold", scnt_b, 15);

    idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
